// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-memory path: word type, RAM handshake
// states and the request arbiter's FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_request_arbiter.sv
// Memory-side responder for one core's instruction and data caches: arbitrates
// the two request streams onto a single-ported RAM and acks via iwait/dwait.
module mem_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      mem_err
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_CYCLES);

    arb_state_t    state_q,  state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q,    tmo_d;
    logic          err_q,    err_d;
    logic          req_live;

    assign iload   = ramload;
    assign dload   = ramload;
    assign mem_err = err_q;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        req_live = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                // Data wins unless it has starved a pending fetch for a full streak.
                if ((dREN || dWEN) && !(iREN && streak_q == STREAK_MAX))
                    state_d = dWEN ? DWRITE : DREAD;
                else if (iREN)
                    state_d = IFETCH;
            end
            IFETCH: begin
                ramREN   = 1'b1;
                ramaddr  = iaddr;
                req_live = iREN;
            end
            DREAD: begin
                ramREN   = 1'b1;
                ramaddr  = daddr;
                req_live = dREN;
            end
            DWRITE: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr;
                ramstore = dstore;
                req_live = dWEN;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (!req_live) begin
                state_d = IDLE;
            end else if (ramstate == ACCESS) begin
                state_d = IDLE;
                if (state_q == IFETCH) begin
                    iwait    = 1'b0;
                    streak_d = '0;
                end else begin
                    dwait = 1'b0;
                    if (!iREN)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + SW'(1);
                end
            end else if (ramstate == ERROR) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else if (tmo_q + TW'(1) == TMO_LIMIT) begin
                // Abort without ack; the requester is still waiting and re-arbitrates.
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: cache-side drivers, a latency-randomised RAM
// model, and a monitor that pops expected responses on every ack.
module tb_mem_request_arbiter;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } iexp_t;

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
    } dexp_t;

    logic      CLK, nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    logic      iwait, dwait, ramREN, ramWEN, mem_err;
    word_t     iload, dload, ramaddr, ramstore;
    ramstate_t ramstate;

    int tests = 0;
    int fails = 0;

    iexp_t iexp_q[$];
    dexp_t dexp_q[$];
    bit    ack_log[$];

    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int ram_mode = 0;
    int lat_min  = 0;
    int lat_max  = 3;
    int lat      = 0;

    mem_request_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // RAM model: random BUSY latency, then one ACCESS cycle
    initial begin
        ramstate = FREE;
        ramload  = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (ram_mode == 1) begin
                ramstate = BUSY;
                lat      = lat_min;
            end else if (ram_mode == 2) begin
                ramstate = ERROR;
                lat      = lat_min;
            end else if (ramREN || ramWEN) begin
                if (lat == 0) begin
                    ramstate = ACCESS;
                    if (ramWEN) ram_mem[ramaddr] = ramstore;
                    else        ramload = ram_rd(ramaddr);
                end else begin
                    ramstate = BUSY;
                    lat--;
                end
            end else begin
                ramstate = FREE;
                lat      = $urandom_range(lat_max, lat_min);
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (nRST) begin
            chk("strobe_exclusive", {31'b0, ramREN & ramWEN}, 32'd0);
            chk("dual_ack", {31'b0, ~iwait & ~dwait}, 32'd0);
            if (!iwait) begin
                ack_log.push_back(1'b1);
                chk("i_spurious_ack", {31'b0, iexp_q.size() == 0}, 32'd0);
                if (iexp_q.size() != 0) begin
                    iexp_t e;
                    e = iexp_q.pop_front();
                    chk("i_ack_ramREN", {31'b0, ramREN}, 32'd1);
                    chk("i_ack_addr", ramaddr, e.addr);
                    chk("i_ack_iload", iload, e.data);
                end
            end
            if (!dwait) begin
                ack_log.push_back(1'b0);
                chk("d_spurious_ack", {31'b0, dexp_q.size() == 0}, 32'd0);
                if (dexp_q.size() != 0) begin
                    dexp_t e;
                    e = dexp_q.pop_front();
                    chk("d_ack_ramWEN", {31'b0, ramWEN}, {31'b0, e.w});
                    chk("d_ack_ramREN", {31'b0, ramREN}, {31'b0, ~e.w});
                    chk("d_ack_addr", ramaddr, e.addr);
                    if (e.w) chk("d_ack_ramstore", ramstore, e.data);
                    else     chk("d_ack_dload", dload, e.data);
                end
            end
        end
    end

    // Driver tasks: called just after a rising edge
    task automatic wait_ack(input logic is_i, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((is_i ? iwait : dwait) && n < 400);
        if (is_i ? iwait : dwait) begin
            tests++;
            fails++;
            $display("FAIL %s: got no ack after %0d cycles required ack", nm, n);
        end
    endtask

    task automatic i_req(input logic [31:0] a);
        iexp_q.push_back('{addr: a, data: ref_rd(a)});
        iaddr = a;
        iREN  = 1'b1;
        wait_ack(1'b1, "i_ack_bound");
        @(posedge CLK);
        #1;
        iREN = 1'b0;
    endtask

    task automatic d_req(input logic w, input logic [31:0] a, input logic [31:0] v);
        dexp_t e;
        e.w    = w;
        e.addr = a;
        if (w) begin
            e.data   = v;
            ref_mem[a] = v;
        end else begin
            e.data = ref_rd(a);
        end
        dexp_q.push_back(e);
        daddr  = a;
        dstore = v;
        dWEN   = w;
        dREN   = ~w;
        wait_ack(1'b0, "d_ack_bound");
        @(posedge CLK);
        #1;
        dREN = 1'b0;
        dWEN = 1'b0;
    endtask

    initial begin
        int n;
        bit exp_pat[$];

        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ram_mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_iwait", {31'b0, iwait}, 32'd1);
        chk("rst_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Fetch with fixed 2-cycle RAM latency
        lat_min = 2; lat_max = 2;
        iexp_q.push_back('{addr: 32'h100, data: 32'hDEAD_BEEF});
        iaddr = 32'h100; iREN = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 2) begin
                chk("fetch_ramREN_c1", {31'b0, ramREN}, 32'd1);
                chk("fetch_ramaddr_c1", ramaddr, 32'h100);
            end
        end while (iwait && n < 50);
        chk("fetch_latency", n, 32'd4);
        @(posedge CLK); #1;
        iREN = 1'b0;
        @(negedge CLK);
        chk("fetch_iwait_one_cycle", {31'b0, iwait}, 32'd1);
        chk("fetch_back_idle", {31'b0, ramREN}, 32'd0);
        @(posedge CLK); #1;

        // Write: ramREN must stay low throughout
        lat_min = 1; lat_max = 1;
        dexp_q.push_back('{w: 1'b1, addr: 32'h40, data: 32'h1234_5678});
        ref_mem[32'h40] = 32'h1234_5678;
        daddr = 32'h40; dstore = 32'h1234_5678; dWEN = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            chk("write_ramREN_low", {31'b0, ramREN}, 32'd0);
        end while (dwait && n < 50);
        chk("write_latency", n, 32'd3);
        @(posedge CLK); #1;
        dWEN = 1'b0;
        d_req(1'b0, 32'h40, 32'h0);

        // Both pending, data first, then fetch-starvation streak limit
        lat_min = 0; lat_max = 3;
        ack_log.delete();
        fork
            begin
                for (int k = 0; k < 3; k++) i_req(32'h10 + k);
            end
            begin
                for (int k = 0; k < 10; k++) d_req(1'b0, 32'h200 + k, 32'h0);
            end
        join
        exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
        chk("streak_ack_count", ack_log.size(), exp_pat.size());
        for (int k = 0; k < exp_pat.size() && k < ack_log.size(); k++)
            chk($sformatf("streak_order_%0d", k), {31'b0, ack_log[k]}, {31'b0, exp_pat[k]});

        // Randomised concurrent traffic
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(3, 0)) begin @(posedge CLK); #1; end
                    i_req($urandom_range(255, 0));
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(3, 0)) begin @(posedge CLK); #1; end
                    d_req($urandom_range(1, 0), 32'h1000 + $urandom_range(15, 0), $urandom);
                end
            end
        join
        chk("random_no_err", {31'b0, mem_err}, 32'd0);

        // Timeout during a fetch
        lat_min = 0; lat_max = 0;
        ram_mode = 1;
        iaddr = 32'h80; iREN = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!ramREN && n < 10);
        n = 0;
        while (ramREN && n < 200) begin
            n++;
            if (n == 64) chk("timeout_err_before", {31'b0, mem_err}, 32'd0);
            chk("timeout_iwait_held", {31'b0, iwait}, 32'd1);
            @(negedge CLK);
        end
        chk("timeout_cycles", n, 32'd64);
        chk("timeout_mem_err", {31'b0, mem_err}, 32'd1);
        chk("timeout_iwait", {31'b0, iwait}, 32'd1);
        @(negedge CLK);
        chk("timeout_regrant", {31'b0, ramREN}, 32'd1);
        chk("timeout_regrant_addr", ramaddr, 32'h80);
        iexp_q.push_back('{addr: 32'h80, data: ref_rd(32'h80)});
        ram_mode = 0;
        wait_ack(1'b1, "timeout_refetch_bound");
        @(posedge CLK); #1;
        iREN = 1'b0;

        // ERROR during a data read, then withdrawal
        lat_min = 3; lat_max = 3;
        ram_mode = 2;
        daddr = 32'h1010; dREN = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!ramREN && n < 10);
        @(negedge CLK);
        chk("error_back_idle", {31'b0, ramREN}, 32'd0);
        chk("error_mem_err", {31'b0, mem_err}, 32'd1);
        chk("error_dwait", {31'b0, dwait}, 32'd1);
        @(posedge CLK); #1;
        dREN = 1'b0;
        ram_mode = 0;
        @(negedge CLK);
        @(negedge CLK);
        chk("withdraw_idle", {31'b0, ramREN}, 32'd0);
        chk("withdraw_dwait", {31'b0, dwait}, 32'd1);
        chk("withdraw_err_sticky", {31'b0, mem_err}, 32'd1);

        // Reset asserted during a data read
        @(posedge CLK); #1;
        daddr = 32'h1020; dREN = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!ramREN && n < 10);
        chk("rst_mid_granted", {31'b0, ramREN}, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("rst_mid_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rst_mid_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("rst_mid_ramaddr", ramaddr, 32'd0);
        chk("rst_mid_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_mid_mem_err", {31'b0, mem_err}, 32'd0);
        dREN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        lat_min = 0; lat_max = 3;
        i_req(32'h100);

        repeat (5) @(posedge CLK);
        chk("final_iexp_empty", iexp_q.size(), 32'd0);
        chk("final_dexp_empty", dexp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
